// File: rtl/snake_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : snake_timer_pkg
// Purpose  : Shared constants and state encoding for the snake timer master:
//            interval-timer register map, control bits and FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package snake_timer_pkg;

    // Interval-timer slave word addresses
    localparam logic [2:0] ADDR_STATUS   = 3'd0;
    localparam logic [2:0] ADDR_CONTROL  = 3'd1;
    localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
    localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
    localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
    localparam logic [2:0] ADDR_SNAP_H   = 3'd5;

    // Control register bit positions
    localparam int CTL_ITO_BIT   = 0;
    localparam int CTL_CONT_BIT  = 1;
    localparam int CTL_START_BIT = 2;
    localparam int CTL_STOP_BIT  = 3;

    // Control words: start continuous with irq enabled, and stop
    localparam logic [15:0] CTL_GO   = 16'h0007;
    localparam logic [15:0] CTL_STOP = 16'h0008;

    // Master sequencer states
    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_WR_PL       = 4'd1,
        ST_WR_PH       = 4'd2,
        ST_WR_CTL_GO   = 4'd3,
        ST_RUN         = 4'd4,
        ST_CLR_ST      = 4'd5,
        ST_WR_CTL_STOP = 4'd6,
        ST_SNAP_WR     = 4'd7,
        ST_RD_L        = 4'd8,
        ST_RD_H        = 4'd9,
        ST_RD_H_CAP    = 4'd10
    } state_t;

endpackage : snake_timer_pkg
`default_nettype wire

// File: rtl/snake_timer_master.sv
`default_nettype none
// ============================================================================
// Module   : snake_timer_master
// Purpose  : Avalon-MM initiator owning the game interval timer. Programs the
//            period, starts/stops continuous mode, services timeouts into a
//            one-cycle game tick and takes counter snapshots on request.
// Revision : 1.0 - initial release
// ============================================================================
module snake_timer_master
    import snake_timer_pkg::*;
#(
    parameter logic [31:0] DEFAULT_PERIOD = 32'h0001_D4BF,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_start,
    input  logic        cmd_stop,
    input  logic        cmd_snap,
    input  logic [31:0] cmd_period,
    output logic        tick,
    output logic [15:0] tick_count,
    output logic        running,
    output logic        busy,
    output logic [31:0] snap_value,
    output logic        snap_valid,
    output logic [2:0]  av_address,
    output logic        av_chipselect,
    output logic        av_write_n,
    output logic [15:0] av_writedata,
    input  logic [15:0] av_readdata,
    input  logic        av_irq
);

    state_t      state, next_state;
    logic        pend_start, pend_stop, pend_snap;
    logic        auto_arm;      // one-shot: raises pend_start after reset release
    logic        guard;         // masks stale irq in the RUN cycle after CLR_ST
    logic        ret_run;       // snapshot entered from RUN rather than IDLE
    logic [31:0] period_hold;   // last commanded period
    logic [31:0] seq_period;    // period frozen for the sequence in flight
    logic [15:0] snap_low;

    logic        want_start, want_stop, want_snap;
    logic        take_start, take_stop, take_snap, take_irq;
    logic [31:0] start_period;
    logic        bus_cs, bus_wn;
    logic [2:0]  bus_addr;
    logic [15:0] bus_data;

    assign want_start   = pend_start | cmd_start;
    assign want_stop    = pend_stop  | cmd_stop;
    assign want_snap    = pend_snap  | cmd_snap;
    assign start_period = cmd_start ? cmd_period : period_hold;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: arbitration from IDLE/RUN, fixed walk through each sequence
    always_comb begin
        next_state = state;
        take_irq   = 1'b0;
        take_stop  = 1'b0;
        take_start = 1'b0;
        take_snap  = 1'b0;
        case (state)
            ST_IDLE, ST_RUN: begin
                if (state == ST_RUN && av_irq && !guard) begin
                    take_irq   = 1'b1;
                    next_state = ST_CLR_ST;
                end else if (want_stop) begin
                    // Stopping an idle timer needs no bus access
                    take_stop  = 1'b1;
                    next_state = (state == ST_RUN) ? ST_WR_CTL_STOP : ST_IDLE;
                end else if (want_start) begin
                    take_start = 1'b1;
                    next_state = ST_WR_PL;
                end else if (want_snap) begin
                    take_snap  = 1'b1;
                    next_state = ST_SNAP_WR;
                end
            end
            ST_WR_PL:       next_state = ST_WR_PH;
            ST_WR_PH:       next_state = ST_WR_CTL_GO;
            ST_WR_CTL_GO:   next_state = ST_RUN;
            ST_CLR_ST:      next_state = ST_RUN;
            ST_WR_CTL_STOP: next_state = ST_IDLE;
            ST_SNAP_WR:     next_state = ST_RD_L;
            ST_RD_L:        next_state = ST_RD_H;
            ST_RD_H:        next_state = ST_RD_H_CAP;
            ST_RD_H_CAP:    next_state = ret_run ? ST_RUN : ST_IDLE;
            default:        next_state = ST_IDLE;
        endcase
    end

    // Bus access for the state being entered, registered below
    always_comb begin
        bus_cs   = 1'b0;
        bus_wn   = 1'b1;
        bus_addr = ADDR_STATUS;
        bus_data = 16'h0000;
        case (next_state)
            ST_WR_PL: begin
                bus_cs   = 1'b1;
                bus_wn   = 1'b0;
                bus_addr = ADDR_PERIOD_L;
                bus_data = take_start ? start_period[15:0] : seq_period[15:0];
            end
            ST_WR_PH: begin
                bus_cs   = 1'b1;
                bus_wn   = 1'b0;
                bus_addr = ADDR_PERIOD_H;
                bus_data = seq_period[31:16];
            end
            ST_WR_CTL_GO: begin
                bus_cs   = 1'b1;
                bus_wn   = 1'b0;
                bus_addr = ADDR_CONTROL;
                bus_data = CTL_GO;
            end
            ST_CLR_ST: begin
                bus_cs   = 1'b1;
                bus_wn   = 1'b0;
                bus_addr = ADDR_STATUS;
            end
            ST_WR_CTL_STOP: begin
                bus_cs   = 1'b1;
                bus_wn   = 1'b0;
                bus_addr = ADDR_CONTROL;
                bus_data = CTL_STOP;
            end
            ST_SNAP_WR: begin
                bus_cs   = 1'b1;
                bus_wn   = 1'b0;
                bus_addr = ADDR_SNAP_L;
            end
            ST_RD_L: begin
                bus_cs   = 1'b1;
                bus_addr = ADDR_SNAP_L;
            end
            ST_RD_H: begin
                bus_cs   = 1'b1;
                bus_addr = ADDR_SNAP_H;
            end
            default: ;
        endcase
    end

    // Registered outputs, pending flags and sequence bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            av_chipselect <= 1'b0;
            av_write_n    <= 1'b1;
            av_address    <= 3'd0;
            av_writedata  <= 16'h0000;
            tick          <= 1'b0;
            tick_count    <= 16'h0000;
            running       <= 1'b0;
            busy          <= 1'b0;
            snap_value    <= 32'h0000_0000;
            snap_valid    <= 1'b0;
            snap_low      <= 16'h0000;
            pend_start    <= 1'b0;
            pend_stop     <= 1'b0;
            pend_snap     <= 1'b0;
            auto_arm      <= AUTO_START;
            guard         <= 1'b0;
            ret_run       <= 1'b0;
            period_hold   <= DEFAULT_PERIOD;
            seq_period    <= DEFAULT_PERIOD;
        end else begin
            av_chipselect <= bus_cs;
            av_write_n    <= bus_wn;
            av_address    <= bus_addr;
            av_writedata  <= bus_data;
            busy          <= !(next_state == ST_IDLE || next_state == ST_RUN);
            tick          <= take_irq;
            if (take_irq) begin
                tick_count <= tick_count + 16'd1;
            end
            guard         <= (state == ST_CLR_ST);

            auto_arm   <= 1'b0;
            pend_start <= (pend_start | cmd_start | auto_arm) & ~take_start;
            pend_stop  <= (pend_stop  | cmd_stop)  & ~take_stop;
            pend_snap  <= (pend_snap  | cmd_snap)  & ~take_snap;

            if (cmd_start) begin
                period_hold <= cmd_period;
            end
            if (take_start) begin
                seq_period <= start_period;
            end

            if (state == ST_WR_CTL_GO) begin
                running <= 1'b1;
            end else if (state == ST_WR_CTL_STOP) begin
                running <= 1'b0;
            end

            if (take_snap) begin
                ret_run <= (state == ST_RUN);
            end
            if (state == ST_RD_H) begin
                snap_low <= av_readdata;
            end
            snap_valid <= (state == ST_RD_H_CAP);
            if (state == ST_RD_H_CAP) begin
                snap_value <= {av_readdata, snap_low};
            end
        end
    end

endmodule : snake_timer_master
`default_nettype wire

// File: tb/tb_snake_timer_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_snake_timer_master
// Purpose  : Directed self-checking bench for snake_timer_master with a small
//            interval-timer slave model (snapshot registers, registered read).
// Revision : 1.0 - initial release
// ============================================================================
module tb_snake_timer_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_start, cmd_stop, cmd_snap;
    logic [31:0] cmd_period;
    logic        tick;
    logic [15:0] tick_count;
    logic        running, busy;
    logic [31:0] snap_value;
    logic        snap_valid;
    logic [2:0]  av_address;
    logic        av_chipselect, av_write_n;
    logic [15:0] av_writedata;
    logic [15:0] av_readdata = 16'h0000;
    logic        av_irq;

    logic [31:0] slave_count;
    logic [31:0] slave_snap = 32'h0000_0000;

    int checks = 0;
    int errors = 0;

    snake_timer_master #(
        .DEFAULT_PERIOD(32'h0001_D4BF),
        .AUTO_START    (1'b1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_start    (cmd_start),
        .cmd_stop     (cmd_stop),
        .cmd_snap     (cmd_snap),
        .cmd_period   (cmd_period),
        .tick         (tick),
        .tick_count   (tick_count),
        .running      (running),
        .busy         (busy),
        .snap_value   (snap_value),
        .snap_valid   (snap_valid),
        .av_address   (av_address),
        .av_chipselect(av_chipselect),
        .av_write_n   (av_write_n),
        .av_writedata (av_writedata),
        .av_readdata  (av_readdata),
        .av_irq       (av_irq)
    );

    always #5 clk = ~clk;

    // Slave model: snapshot capture on write to 4/5, registered read data
    always @(posedge clk) begin
        if (av_chipselect && !av_write_n && (av_address == 3'd4 || av_address == 3'd5))
            slave_snap <= slave_count;
        if (av_chipselect && av_write_n)
            av_readdata <= (av_address == 3'd4) ? slave_snap[15:0] :
                           (av_address == 3'd5) ? slave_snap[31:16] : 16'h0000;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expect a one-cycle write of data to addr in the current cycle
    task automatic check_wr(input string tag, input logic [2:0] addr, input logic [15:0] data);
        check({tag, "_cs"},   {31'd0, av_chipselect}, 32'd1);
        check({tag, "_wn"},   {31'd0, av_write_n},    32'd0);
        check({tag, "_addr"}, {29'd0, av_address},    {29'd0, addr});
        check({tag, "_data"}, {16'd0, av_writedata},  {16'd0, data});
    endtask

    task automatic check_rd(input string tag, input logic [2:0] addr);
        check({tag, "_cs"},   {31'd0, av_chipselect}, 32'd1);
        check({tag, "_wn"},   {31'd0, av_write_n},    32'd1);
        check({tag, "_addr"}, {29'd0, av_address},    {29'd0, addr});
    endtask

    initial begin
        reset = 1'b1; cmd_start = 1'b0; cmd_stop = 1'b0; cmd_snap = 1'b0;
        cmd_period = 32'h0; av_irq = 1'b0; slave_count = 32'h0001_2345;
        step(); step(); step();

        // Reset state
        check("rst_cs",      {31'd0, av_chipselect}, 32'd0);
        check("rst_wn",      {31'd0, av_write_n},    32'd1);
        check("rst_addr",    {29'd0, av_address},    32'd0);
        check("rst_wdata",   {16'd0, av_writedata},  32'd0);
        check("rst_tick",    {31'd0, tick},          32'd0);
        check("rst_tcount",  {16'd0, tick_count},    32'd0);
        check("rst_running", {31'd0, running},       32'd0);
        check("rst_busy",    {31'd0, busy},          32'd0);
        check("rst_snapv",   {31'd0, snap_valid},    32'd0);
        check("rst_snap",    snap_value,             32'd0);

        // Auto-start: three consecutive writes, then running
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!av_chipselect) step();
        end
        check("auto_seen", {31'd0, av_chipselect}, 32'd1);
        check_wr("auto_pl", 3'd2, 16'hD4BF);
        check("auto_busy", {31'd0, busy}, 32'd1);
        step(); check_wr("auto_ph", 3'd3, 16'h0001);
        step(); check_wr("auto_go", 3'd1, 16'h0007);
        step();
        check("auto_idle_cs", {31'd0, av_chipselect}, 32'd0);
        check("auto_running", {31'd0, running},       32'd1);
        check("auto_busy0",   {31'd0, busy},          32'd0);

        // IRQ service; irq held across the clear and guard cycle gives one tick
        av_irq = 1'b1;
        step();
        check_wr("svc_clr", 3'd0, 16'h0000);
        check("svc_tick",   {31'd0, tick},       32'd1);
        check("svc_count",  {16'd0, tick_count}, 32'd1);
        step();
        check("svc_tick_off", {31'd0, tick},          32'd0);
        check("svc_cs_off",   {31'd0, av_chipselect}, 32'd0);
        step();
        av_irq = 1'b0;
        check("svc_guard_tick",  {31'd0, tick},          32'd0);
        check("svc_guard_cs",    {31'd0, av_chipselect}, 32'd0);
        check("svc_guard_count", {16'd0, tick_count},    32'd1);
        step();

        // Snapshot from RUN
        cmd_snap = 1'b1;
        step();
        cmd_snap = 1'b0;
        check_wr("snap_wr", 3'd4, 16'h0000);
        step(); check_rd("snap_rdl", 3'd4);
        step(); check_rd("snap_rdh", 3'd5);
        step(); check("snap_cap_cs", {31'd0, av_chipselect}, 32'd0);
        step();
        check("snap_valid",  {31'd0, snap_valid}, 32'd1);
        check("snap_value",  snap_value,          32'h0001_2345);
        step();
        check("snap_valid0", {31'd0, snap_valid}, 32'd0);
        check("snap_running", {31'd0, running},   32'd1);

        // Stop and snapshot together: stop first, snapshot from IDLE
        slave_count = 32'h00AB_CDEF;
        cmd_stop = 1'b1; cmd_snap = 1'b1;
        step();
        cmd_stop = 1'b0; cmd_snap = 1'b0;
        check_wr("ss_stop", 3'd1, 16'h0008);
        step();
        check("ss_running0", {31'd0, running},       32'd0);
        check("ss_gap_cs",   {31'd0, av_chipselect}, 32'd0);
        step(); check_wr("ss_snap_wr", 3'd4, 16'h0000);
        step(); check_rd("ss_rdl", 3'd4);
        step(); check_rd("ss_rdh", 3'd5);
        step(); step();
        check("ss_snap_valid", {31'd0, snap_valid}, 32'd1);
        check("ss_snap_value", snap_value,          32'h00AB_CDEF);
        check("ss_busy",       {31'd0, busy},       32'd0);
        check("ss_running",    {31'd0, running},    32'd0);
        // IDLE ignores irq
        av_irq = 1'b1;
        step(); step();
        check("idle_irq_cs",   {31'd0, av_chipselect}, 32'd0);
        check("idle_irq_tick", {31'd0, tick},          32'd0);
        av_irq = 1'b0;
        step();

        // IRQ raised during start sequence is serviced after WR_CTL_GO
        cmd_start = 1'b1; cmd_period = 32'h0000_0100;
        step();
        cmd_start = 1'b0;
        check_wr("st_pl", 3'd2, 16'h0100);
        av_irq = 1'b1;
        step(); check_wr("st_ph", 3'd3, 16'h0000);
        check("st_ph_tick", {31'd0, tick}, 32'd0);
        step(); check_wr("st_go", 3'd1, 16'h0007);
        check("st_go_tick", {31'd0, tick}, 32'd0);
        step();
        check("st_run_cs",   {31'd0, av_chipselect}, 32'd0);
        check("st_running",  {31'd0, running},       32'd1);
        step();
        check_wr("st_clr", 3'd0, 16'h0000);
        check("st_tick",  {31'd0, tick},       32'd1);
        check("st_count", {16'd0, tick_count}, 32'd2);
        av_irq = 1'b0;
        step();
        check("st_tick_off", {31'd0, tick}, 32'd0);
        step();

        // Reset in the middle of a start sequence
        cmd_start = 1'b1; cmd_period = 32'h1234_5678;
        step();
        cmd_start = 1'b0;
        check_wr("mid_pl", 3'd2, 16'h5678);
        reset = 1'b1;
        step();
        check("mid_cs",      {31'd0, av_chipselect}, 32'd0);
        check("mid_wn",      {31'd0, av_write_n},    32'd1);
        check("mid_running", {31'd0, running},       32'd0);
        check("mid_count",   {16'd0, tick_count},    32'd0);
        check("mid_busy",    {31'd0, busy},          32'd0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_snake_timer_master
`default_nettype wire
